// File: rtl/cpu_pipeline_pkg.sv
// Shared constants and types for the pipelined CPU stage registers.
package cpu_pipeline_pkg;

    // Payload widths of the four inter-stage registers
    localparam int unsigned IF_ID_W  = 96;
    localparam int unsigned ID_EX_W  = 280;
    localparam int unsigned EX_MEM_W = 203;
    localparam int unsigned MEM_WB_W = 135;

    // Bubble instruction inserted whenever a stage is empty
    localparam logic [31:0] NOP_INSTR = 32'h0;

    // Control bundle layout carried through the pipeline: WB bits lowest, then M, then EX
    localparam int unsigned WB_W   = 2;
    localparam int unsigned M_W    = 3;
    localparam int unsigned EX_W   = 4;
    localparam int unsigned WB_LSB = 0;
    localparam int unsigned M_LSB  = WB_LSB + WB_W;
    localparam int unsigned EX_LSB = M_LSB + M_W;
    localparam int unsigned CTRL_W = EX_LSB + EX_W;

    typedef struct packed {
        logic [EX_W-1:0] ex;
        logic [M_W-1:0]  m;
        logic [WB_W-1:0] wb;
    } ctrl_bundle_t;

    // Width of the back-pressure statistics counter
    localparam int unsigned STALL_CNT_W = 32;

    // Pointer width for a buffer of the given depth; a single-entry buffer still keeps a 1-bit pointer
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for performance statistics; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int n = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    output logic [n-1:0] value
);

    // Count up on inc until every bit is set, cleared only by the asynchronous reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            value <= '0;
        end else if (inc && (value != '1)) begin
            value <= value + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_stage_buffer.sv
// Elastic inter-stage register: DEPTH-entry circular buffer with valid/ready handshake,
// synchronous flush, bubble output when empty and a saturating stall counter.
module pipeline_stage_buffer
    import cpu_pipeline_pkg::*;
#(
    parameter int unsigned       WIDTH        = IF_ID_W,
    parameter int unsigned       DEPTH        = 2,
    parameter logic [WIDTH-1:0]  BUBBLE_VALUE = '0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [STALL_CNT_W-1:0]     stall_cycles
);

    localparam int unsigned      CNT_W      = $clog2(DEPTH + 1);
    localparam int unsigned      PTR_W      = ptr_width(DEPTH);
    localparam int unsigned      MEM_SLOTS  = 1 << PTR_W;
    localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    // Storage is sized to the full pointer range so every pointer value indexes a real slot;
    // slots at or beyond DEPTH are never written because the pointers wrap at DEPTH-1.
    logic [WIDTH-1:0] mem [MEM_SLOTS];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] head_next;
    logic [PTR_W-1:0] tail_next;
    logic [CNT_W-1:0] count_q;
    logic             push;
    logic             pop;
    logic             stall_inc;

    // A single-entry stage must accept while its occupant leaves to reach full throughput;
    // deeper buffers keep in_ready a function of held state only.
    generate
        if (DEPTH == 1) begin : g_single
            assign in_ready = ((count_q == '0) | out_ready) & ~flush;
        end else begin : g_skid
            assign in_ready = (count_q < FULL_COUNT) & ~flush;
        end
    endgenerate

    assign out_valid = (count_q != '0) & ~flush;
    assign out_data  = out_valid ? mem[head] : BUBBLE_VALUE;
    assign count     = count_q;

    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign stall_inc = out_valid & ~out_ready;

    assign head_next = (head == PTR_LAST) ? '0 : head + 1'b1;
    assign tail_next = (tail == PTR_LAST) ? '0 : tail + 1'b1;

    // Pointer and occupancy bookkeeping; flush empties the buffer and rewinds both pointers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else if (flush) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                tail <= tail_next;
            end
            if (pop) begin
                head <= head_next;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (!push && pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Payload storage is deliberately left without reset; invalid slots are masked by the bubble
    always_ff @(posedge clock) begin
        if (push) begin
            mem[tail] <= in_data;
        end
    end

    sat_counter #(
        .n(STALL_CNT_W)
    ) u_stall_counter (
        .clock(clock),
        .reset(reset),
        .inc  (stall_inc),
        .value(stall_cycles)
    );

endmodule
